// File: rtl/bscan_chain.sv
// bscan_chain: boundary-scan data register with capture/shift/update enables, shift counter and safe update value.
// Optional 1-bit bypass path is compiled in with BSCAN_BYPASS_EN.
module bscan_chain #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] SAFE_VAL = '0,
  localparam int CW = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef BSCAN_BYPASS_EN
  input  logic             bypass,
`endif
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             sin,
  output logic             sout,
  input  logic             capturedr,
  input  logic             shiftdr,
  input  logic             updatedr,
  input  logic             mode,
  output logic [CW-1:0]    shift_cnt,
  output logic             chain_full
);
  logic [WIDTH-1:0] r_cap, r_upd, w_shift;
  logic [CW-1:0]    r_cnt;
  logic             w_bsel;
  assign w_shift = (r_cap >> 1) | (WIDTH'(sin) << (WIDTH-1));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap <= '0;
      r_upd <= SAFE_VAL;
      r_cnt <= '0;
    end else begin
      if (updatedr) r_upd <= r_cap;
      if (!w_bsel && capturedr) begin
        r_cap <= data_in;
        r_cnt <= '0;
      end else if (!w_bsel && shiftdr) begin
        r_cap <= w_shift;
        r_cnt <= chain_full ? r_cnt : r_cnt + 1'b1;
      end
    end
  end
`ifdef BSCAN_BYPASS_EN
  logic r_byp;
  assign w_bsel = bypass;
  always_ff @(posedge clk) begin
    if (rst) r_byp <= 1'b0;
    else if (bypass && capturedr) r_byp <= 1'b0;
    else if (bypass && shiftdr) r_byp <= sin;
  end
  assign sout = bypass ? r_byp : r_cap[0];
`else
  assign w_bsel = 1'b0;
  assign sout = r_cap[0];
`endif
  assign data_out   = mode ? r_upd : data_in;
  assign shift_cnt  = r_cnt;
  assign chain_full = (r_cnt == CW'(WIDTH));
endmodule

// File: doc/bscan_chain.md
# bscan_chain

Parametrised boundary-scan data register of `WIDTH` cells on a single clock. It replaces per-cell capture/update flops that were clocked by separate strobes: `capturedr`, `shiftdr` and `updatedr` are now synchronous enables. It adds a shift counter with a full flag, a parametrised safe value for the update stage, and an optional 1-bit bypass path. It sits between the device pins/core logic and the TAP controller, which drives the enables.

## Interface
- `WIDTH`, default 8: number of scan cells; must be ≥ 1.
- `SAFE_VAL`, default 0: `WIDTH`-bit value loaded into the update stage on reset.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `data_in`  in  `WIDTH`  functional inputs, i.e. the pin/core values.
- `data_out`  out  `WIDTH`  functional outputs.
- `sin`  in  1  serial scan input.
- `sout`  out  1  serial scan output.
- `capturedr`  in  1  capture enable.
- `shiftdr`  in  1  shift enable.
- `updatedr`  in  1  update enable.
- `mode`  in  1  output select: 0 = `data_in` passes through, 1 = update stage drives the output.
- `shift_cnt`  out  `CW` = `$clog2(WIDTH+1)`  shift cycles since the last capture; saturates at `WIDTH`.
- `chain_full`  out  1  high when `shift_cnt == WIDTH`.
- `bypass`  in  1  present only with `BSCAN_BYPASS_EN`; selects the bypass register.

## Operation
- **State:**
  - `cap[WIDTH-1:0]` is the capture/shift stage.
  - `upd[WIDTH-1:0]` is the update stage.
  - `cnt` is the shift counter.
  - `byp` is the bypass flop (macro only).
- **Reset** (`rst`=1, highest priority):
  - `cap` ← 0, `upd` ← `SAFE_VAL`, `cnt` ← 0, `byp` ← 0.
  - All other enables are ignored that cycle.
  - Reset in the middle of a shift aborts it; no partial update occurs.
- **Capture/shift stage priority:** `capturedr` > `shiftdr` > hold.
  - **Capture:** `cap` ← `data_in`, `cnt` ← 0.
  - **Shift:** `cap` ← {`sin`, `cap[WIDTH-1:1]`}.
    - `sin` enters at the MSB.
    - Bit 0 leaves the chain, so data moves out LSB first.
    - `cnt` ← min(`cnt`+1, `WIDTH`).
  - Capture and shift asserted together: capture wins and the shift is dropped.
- **Update:** when `updatedr` is high, `upd` ← `cap`, using the value held before any shift or capture in the same cycle.
  - This operates independently of the capture/shift priority chain.
  - `cnt` is unaffected.
- **Outputs:**
  - `sout` = `cap[0]`, combinational from the register (or `byp` when bypassed).
  - `data_out` = `mode` ? `upd` : `data_in`, purely combinational.
  - `chain_full` = (`cnt` == `WIDTH`).
- **WIDTH = 1:**
  - A shift gives `cap` ← `sin`.
  - `cnt` saturates at 1 after one shift.

## Timing
- **Reset values:**
  - `sout` = 0, `shift_cnt` = 0, `chain_full` = 0.
  - `data_out` = `SAFE_VAL` when `mode`=1, otherwise `data_in`.
- **Capture:** `data_in` is sampled at the edge where `capturedr`=1. `sout` shows `data_in[0]` right after that edge.
- **Shift latency:**
  - A bit presented on `sin` at shift edge k reaches `sout` after shift edge k+`WIDTH`-1.
  - The chain is fully replaced after `WIDTH` shift edges.
- **Update:** `upd` and `data_out` (`mode`=1) change right after the edge where `updatedr`=1.
- **Mode:** a `mode` change affects `data_out` in the same cycle, with no register in the path.
- **Enables:**
  - Enables are level-sampled every edge.
  - Holding `shiftdr` high for N cycles performs N shifts.
- **Counter:** `cnt` stays saturated at `WIDTH` under further shifts until the next capture or reset.

## Configuration
- Macro `BSCAN_BYPASS_EN`.
- **Defined:**
  - The `bypass` port and the `byp` flop exist.
  - With `bypass`=1:
    - `capturedr` gives `byp` ← 0.
    - `shiftdr` gives `byp` ← `sin`.
    - `sout` = `byp`.
    - `cap` and `cnt` hold.
    - `updatedr` still copies `cap` to `upd`.
  - With `bypass`=0, behaviour is identical to the macro being undefined.
- **Undefined:** there is no `bypass` port and no `byp` flop; `sout` is always `cap[0]`.

## Test plan
1. **Reset.** Use `WIDTH`=8, `SAFE_VAL`=8'hA5. Assert `rst` for 2 cycles with `mode`=1 → `data_out`=8'hA5, `sout`=0, `shift_cnt`=0, `chain_full`=0. Then set `mode`=0 with `data_in`=8'h0F → `data_out`=8'h0F in the same cycle.
2. **Capture and shift out.** Capture with `data_in`=8'h3C, then apply 8 shifts with `sin`=0. `sout` immediately after the capture edge and after each of the first 7 shift edges reads 0,0,1,1,1,1,0,0. After the 8th edge, `cap`=8'h00, `shift_cnt`=8, `chain_full`=1.
3. **Shift in and update.** Shift in 8'h96 LSB-first over 8 cycles, then pulse `updatedr` → `data_out`=8'h96 (`mode`=1). Switch to `mode`=0 → `data_out`=`data_in`.
4. **Simultaneous enables.**
   - `capturedr`=`shiftdr`=1 with `data_in`=8'h81 → `cap`=8'h81, `shift_cnt`=0.
   - Then `shiftdr`=`updatedr`=1 with `sin`=1 → `upd`=8'h81, `cap`=8'hC0.
5. **Saturation and mid-shift reset.** Apply 10 consecutive shifts → `shift_cnt` stays 8. Apply `rst` during shift 3 of a new sequence → `cap`=0, `upd`=8'hA5, `shift_cnt`=0.
6. **Bypass (`BSCAN_BYPASS_EN`).** With `bypass`=1, apply a single `sin`=1 shift → `sout`=1 after that edge, while `cap` and `shift_cnt` are unchanged. A capture then clears `sout` to 0.
